sv32_ptw: RTL and testbench

SV32_PTW -- requirements
Module: sv32_ptw

---
 rtl/sv32_ptw.sv | 136 +++++++++++++
 tb/tb_sv32_ptw.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sv32_ptw.sv
// ============================================================================
// Module   : sv32_ptw
// Brief    : Sv32 two-level page-table walker for the instruction-side TLB.
//            Optional macro PTW_AD_CHECK_EN faults leaf PTEs with A=0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sv32_ptw #(
  parameter int PTE_AW = 34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              walk_req_i,
  input  logic [19:0]       walk_vpn_i,
  input  logic [21:0]       satp_ppn_i,
  input  logic              flush_i,
  output logic              walk_ready_o,
  output logic              mem_req_o,
  output logic [PTE_AW-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              tlb_update_o,
  output logic [19:0]       tlb_vpn_o,
  output logic [31:0]       tlb_pte_o,
  output logic              tlb_page_4m_o,
  output logic              walk_fault_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_L1_REQ = 3'd1,
    S_L0_REQ = 3'd2,
    S_UPDATE = 3'd3,
    S_FAULT  = 3'd4,
    S_ABORT  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [19:0] r_vpn;
  logic [21:0] r_satp;
  logic [31:0] r_pte;
  logic        r_4m;
  logic        w_latch;
  logic        w_4m_nxt;

  logic w_pte_invalid;
  logic w_pte_leaf;
  logic w_misaligned;
  logic w_ad_fault;

  assign w_pte_invalid = ~mem_rdata_i[0] | (~mem_rdata_i[1] & mem_rdata_i[2]);
  assign w_pte_leaf    = mem_rdata_i[1] | mem_rdata_i[3];
  assign w_misaligned  = |mem_rdata_i[19:10];

`ifdef PTW_AD_CHECK_EN
  assign w_ad_fault = ~mem_rdata_i[6];
`else
  assign w_ad_fault = 1'b0;
`endif

  // Address arithmetic is done at PTE_AW bits; carries beyond it are dropped.
  logic [PTE_AW-1:0] w_l1_addr;
  logic [PTE_AW-1:0] w_l0_addr;
  assign w_l1_addr = PTE_AW'({r_satp, 12'b0}) + PTE_AW'({r_vpn[19:10], 2'b00});
  assign w_l0_addr = PTE_AW'({r_pte[31:10], 12'b0}) + PTE_AW'({r_vpn[9:0], 2'b00});

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_4m_nxt    = r_4m;
    case (r_state)
      S_IDLE: begin
        if (walk_req_i) w_state_nxt = S_L1_REQ;
      end
      S_L1_REQ, S_L0_REQ: begin
        if (flush_i) begin
          w_state_nxt = mem_ack_i ? S_IDLE : S_ABORT;
        end else if (mem_ack_i) begin
          w_latch  = 1'b1;
          w_4m_nxt = (r_state == S_L1_REQ);
          if (w_pte_invalid) begin
            w_state_nxt = S_FAULT;
          end else if (w_pte_leaf) begin
            if (w_ad_fault || ((r_state == S_L1_REQ) && w_misaligned))
              w_state_nxt = S_FAULT;
            else
              w_state_nxt = S_UPDATE;
          end else begin
            w_state_nxt = (r_state == S_L1_REQ) ? S_L0_REQ : S_FAULT;
          end
        end
      end
      S_UPDATE, S_FAULT: w_state_nxt = S_IDLE;
      // The outstanding read must complete before a new walk may issue one.
      S_ABORT: begin
        if (mem_ack_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vpn   <= 20'd0;
      r_satp  <= 22'd0;
      r_pte   <= 32'd0;
      r_4m    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && walk_req_i) begin
        r_vpn  <= walk_vpn_i;
        r_satp <= satp_ppn_i;
      end
      if (w_latch) begin
        r_pte <= mem_rdata_i;
        r_4m  <= w_4m_nxt;
      end
    end
  end

  assign walk_ready_o  = (r_state == S_IDLE);
  assign mem_req_o     = (r_state == S_L1_REQ) || (r_state == S_L0_REQ);
  assign mem_addr_o    = (r_state == S_L1_REQ) ? w_l1_addr :
                         (r_state == S_L0_REQ) ? w_l0_addr : '0;
  assign tlb_update_o  = (r_state == S_UPDATE);
  assign walk_fault_o  = (r_state == S_FAULT);
  assign tlb_vpn_o     = r_vpn;
  assign tlb_pte_o     = r_pte;
  assign tlb_page_4m_o = r_4m;

endmodule

`default_nettype wire

// File: tb/tb_sv32_ptw.sv
// ============================================================================
// Module   : tb_sv32_ptw
// Brief    : Directed self-checking bench for sv32_ptw.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sv32_ptw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        walk_req_i = 1'b0;
  logic [19:0] walk_vpn_i = '0;
  logic [21:0] satp_ppn_i = '0;
  logic        flush_i = 1'b0;
  logic        walk_ready_o;
  logic        mem_req_o;
  logic [33:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        tlb_update_o;
  logic [19:0] tlb_vpn_o;
  logic [31:0] tlb_pte_o;
  logic        tlb_page_4m_o;
  logic        walk_fault_o;

  int n_tests = 0;
  int n_fail  = 0;

  sv32_ptw #(.PTE_AW(34)) dut (
    .clk          (clk),
    .rst          (rst),
    .walk_req_i   (walk_req_i),
    .walk_vpn_i   (walk_vpn_i),
    .satp_ppn_i   (satp_ppn_i),
    .flush_i      (flush_i),
    .walk_ready_o (walk_ready_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .tlb_update_o (tlb_update_o),
    .tlb_vpn_o    (tlb_vpn_o),
    .tlb_pte_o    (tlb_pte_o),
    .tlb_page_4m_o(tlb_page_4m_o),
    .walk_fault_o (walk_fault_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait walk: acks each request in its first cycle and measures latency.
  task automatic walk(input string tag, input logic [19:0] vpn, input logic [21:0] satp,
                      input logic [31:0] p1, input logic [31:0] p0,
                      input logic [33:0] a1, input logic [33:0] a0,
                      input int exp_reqs, input bit exp_upd, input bit exp_4m,
                      input int exp_lat);
    int cyc;
    int n;
    bit got_upd;
    bit got_flt;
    walk_req_i = 1'b1;
    walk_vpn_i = vpn;
    satp_ppn_i = satp;
    check_eq({tag, " ready"}, walk_ready_o, 1);
    step();
    walk_req_i = 1'b0;
    cyc = 1; n = 0; got_upd = 0; got_flt = 0;
    while (cyc < 20) begin
      mem_ack_i = 1'b0;
      if (tlb_update_o || walk_fault_o) begin
        got_upd = tlb_update_o;
        got_flt = walk_fault_o;
        break;
      end
      if (mem_req_o) begin
        if (n == 0) check_eq({tag, " addr1"}, mem_addr_o, a1);
        else        check_eq({tag, " addr0"}, mem_addr_o, a0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = (n == 0) ? p1 : p0;
        n++;
      end
      step();
      cyc++;
    end
    mem_ack_i = 1'b0;
    check_eq({tag, " update"}, got_upd, exp_upd);
    check_eq({tag, " fault"}, got_flt, !exp_upd);
    check_eq({tag, " latency"}, cyc, exp_lat);
    check_eq({tag, " reqs"}, n, exp_reqs);
    if (exp_upd) begin
      check_eq({tag, " vpn"}, tlb_vpn_o, vpn);
      check_eq({tag, " pte"}, tlb_pte_o, (exp_reqs == 1) ? p1 : p0);
      check_eq({tag, " 4m"}, tlb_page_4m_o, exp_4m);
    end
    step();
    check_eq({tag, " pulse end"}, {tlb_update_o, walk_fault_o}, 2'b00);
    check_eq({tag, " ready end"}, walk_ready_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    rst = 1'b0;
    check_eq("rst ready", walk_ready_o, 1);
    check_eq("rst outs", {mem_req_o, tlb_update_o, walk_fault_o, tlb_page_4m_o}, 4'b0);
    check_eq("rst addr", mem_addr_o, 0);
    check_eq("rst vpn", tlb_vpn_o, 0);
    check_eq("rst pte", tlb_pte_o, 0);

    walk("super", 20'h40100, 22'h00080, 32'h200000CF, 32'h0,
         34'h80400, 34'h0, 1, 1'b1, 1'b1, 2);
    walk("4k", 20'h40100, 22'h00080, 32'h20001001, 32'h200020CB,
         34'h80400, 34'h80004400, 2, 1'b1, 1'b0, 3);
    walk("l1 inval", 20'h40100, 22'h00080, 32'h00000000, 32'h0,
         34'h80400, 34'h0, 1, 1'b0, 1'b0, 2);
    walk("l0 nonleaf", 20'h40100, 22'h00080, 32'h20001001, 32'h20002001,
         34'h80400, 34'h80004400, 2, 1'b0, 1'b0, 3);
    walk("misalign", 20'h40100, 22'h00080, 32'h200004CF, 32'h0,
         34'h80400, 34'h0, 1, 1'b0, 1'b0, 2);
    walk("rw res", 20'h00001, 22'h00001, 32'h20000005, 32'h0,
         34'h1000, 34'h0, 1, 1'b0, 1'b0, 2);
`ifdef PTW_AD_CHECK_EN
    walk("a bit", 20'h40100, 22'h00080, 32'h2000008F, 32'h0,
         34'h80400, 34'h0, 1, 1'b0, 1'b0, 2);
`else
    walk("a bit", 20'h40100, 22'h00080, 32'h2000008F, 32'h0,
         34'h80400, 34'h0, 1, 1'b1, 1'b1, 2);
`endif

    // Flush in L0_REQ, ack arrives three cycles later.
    walk_req_i = 1'b1; walk_vpn_i = 20'h40100; satp_ppn_i = 22'h00080;
    step();
    walk_req_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h20001001;
    step();
    mem_ack_i = 1'b0;
    check_eq("abort l0 req", mem_req_o, 1);
    check_eq("abort l0 addr", mem_addr_o, 34'h80004400);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check_eq("abort req drop", mem_req_o, 0);
    check_eq("abort busy", walk_ready_o, 0);
    step();
    step();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h200020CB;
    check_eq("abort pre-ack", walk_ready_o, 0);
    step();
    mem_ack_i = 1'b0;
    check_eq("abort ready", walk_ready_o, 1);
    check_eq("abort pulses", {tlb_update_o, walk_fault_o}, 2'b00);
    step();
    check_eq("abort pulses2", {tlb_update_o, walk_fault_o}, 2'b00);

    // Flush with ack in the same L1_REQ cycle.
    walk_req_i = 1'b1;
    step();
    walk_req_i = 1'b0; flush_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h200000CF;
    step();
    flush_i = 1'b0; mem_ack_i = 1'b0;
    check_eq("flush ack ready", walk_ready_o, 1);
    check_eq("flush ack pulses", {tlb_update_o, walk_fault_o, mem_req_o}, 3'b000);

    // Flush during UPDATE leaves the pulse intact.
    walk_req_i = 1'b1; walk_vpn_i = 20'h12345;
    step();
    walk_req_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h200000CF;
    step();
    mem_ack_i = 1'b0; flush_i = 1'b1;
    check_eq("flush upd pulse", tlb_update_o, 1);
    check_eq("flush upd vpn", tlb_vpn_o, 20'h12345);
    step();
    flush_i = 1'b0;
    check_eq("flush upd idle", {walk_ready_o, tlb_update_o}, 2'b10);

    // Reset while in L1_REQ, then a stray ack.
    walk_req_i = 1'b1; walk_vpn_i = 20'h40100;
    step();
    walk_req_i = 1'b0;
    check_eq("rstwalk in l1", mem_req_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rstwalk ready", walk_ready_o, 1);
    check_eq("rstwalk outs", {mem_req_o, tlb_update_o, walk_fault_o, tlb_page_4m_o}, 4'b0);
    check_eq("rstwalk addr", mem_addr_o, 0);
    check_eq("rstwalk vpn", tlb_vpn_o, 0);
    check_eq("rstwalk pte", tlb_pte_o, 0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h200000CF;
    step();
    mem_ack_i = 1'b0;
    check_eq("stray ack", {walk_ready_o, mem_req_o, tlb_update_o, walk_fault_o}, 4'b1000);
    step();
    check_eq("stray ack2", {walk_ready_o, tlb_update_o, walk_fault_o, tlb_pte_o}, {3'b100, 32'h0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
